// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with a valid/ready
// handshake and a 2-entry skid buffer (main entry M drives the outputs, skid
// entry S catches the beat accepted while M is stalled).
// Optional macro PIPE_STAGE_STALL_CNT_EN enables a saturating stall counter
// on stall_cnt; without it stall_cnt is tied to zero.
module pipe_stage_skid #(
  parameter int CTRL_W             = 16,
  parameter int DATA_W             = 128,
  parameter int ZERO_DATA_ON_FLUSH = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level,
  output logic [31:0]       stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic in_fire;
  logic out_fire;
  logic m_free;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = !s_valid_q && !Reset;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid_q && out_ready;
  assign m_free    = !m_valid_q || out_fire;

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign level     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  // Next-state for both entries: flush squashes, otherwise M refills from S
  // first (FIFO order), then from the input; a stalled M diverts input to S.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (Flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
      if (ZERO_DATA_ON_FLUSH != 0) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else if (m_free) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // in_fire implies S is empty, so S is never overwritten here.
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_data_d  = in_data;
    end
  end

  // Entry registers with synchronous reset clearing every field.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where a valid output is held back; saturate, reset-only clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (m_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus pushes expected beats into a
// queue, a negedge monitor pops and compares on every output handshake.
module tb_pipe_stage_skid;
  localparam int CW = 16;
  localparam int DW = 128;

  logic          Clk = 1'b0;
  logic          Reset, Flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    level;
  logic [31:0]   stall_cnt;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b;
  int    total = 0;
  int    bad   = 0;
  logic [31:0] exp_stall5;

  always #5 Clk = ~Clk;

  pipe_stage_skid dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .level(level), .stall_cnt(stall_cnt)
  );

  function automatic logic [CW-1:0] mk_ctrl(input logic [7:0] tag, input int n);
    return {tag, 8'(n)};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [7:0] tag, input int n);
    return {tag, 88'h0, 32'(n)};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_in();
    @(posedge Clk);
    #1;
  endtask

  // Drive a beat and optionally record it as an expected output.
  task automatic drive(input logic [7:0] tag, input int n, input bit expect_out);
    beat_t b;
    in_valid = 1'b1;
    in_ctrl  = mk_ctrl(tag, n);
    in_data  = mk_data(tag, n);
    if (expect_out) begin
      b.c = in_ctrl;
      b.d = in_data;
      sb.push_back(b);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_left", DW'(sb.size()), '0);
  endtask

  // Output monitor: one line per consumed beat.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (!out_valid) chk("ctrl_mask", DW'(out_ctrl), '0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got ctrl=%0h data=%0h required none", out_ctrl, out_data);
        end else begin
          exp_b = sb.pop_front();
          $display("out beat ctrl=%0h data=%0h", out_ctrl, out_data);
          chk("sb_ctrl", DW'(out_ctrl), DW'(exp_b.c));
          chk("sb_data", out_data, exp_b.d);
        end
      end
    end
  end

  initial begin
`ifdef PIPE_STAGE_STALL_CNT_EN
    exp_stall5 = 32'd5;
`else
    exp_stall5 = 32'd0;
`endif
    Reset = 1'b1; Flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = '1;

    // Reset with a valid input held throughout
    repeat (3) begin
      @(negedge Clk);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_out_ctrl", DW'(out_ctrl), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_level", DW'(level), '0);
      chk("rst_in_ready", DW'(in_ready), '0);
    end
    edge_in();
    Reset = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    @(negedge Clk);
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));
    chk("post_rst_out_valid", DW'(out_valid), '0);

    // Stream A1..A8 with out_ready=1
    edge_in();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) edge_in();
      drive(8'hA0, i, 1'b1);
      @(negedge Clk);
      chk("a_in_ready", DW'(in_ready), DW'(1));
      chk("a_level_le1", DW'(level > 2'd1), '0);
      if (i > 1) begin
        chk("a_out_valid", DW'(out_valid), DW'(1));
        chk("a_latency", out_data, mk_data(8'hA0, i - 1));
      end
    end
    edge_in();
    in_valid = 1'b0;
    @(negedge Clk);
    chk("a_last", out_data, mk_data(8'hA0, 8));
    edge_in();
    @(negedge Clk);
    chk("a_empty_level", DW'(level), '0);

    // Back-pressure: B1 in M, B2 in S, B3 held upstream
    edge_in();
    out_ready = 1'b0;
    drive(8'hB0, 1, 1'b1);
    edge_in();
    drive(8'hB0, 2, 1'b1);
    @(negedge Clk);
    chk("b_level1", DW'(level), DW'(1));
    edge_in();
    drive(8'hB0, 3, 1'b1);
    @(negedge Clk);
    chk("b_level2", DW'(level), DW'(2));
    chk("b_full_in_ready", DW'(in_ready), '0);
    chk("b_hold_data", out_data, mk_data(8'hB0, 1));
    repeat (2) edge_in();
    @(negedge Clk);
    chk("b_stable_data", out_data, mk_data(8'hB0, 1));
    chk("b_stable_ctrl", DW'(out_ctrl), DW'(mk_ctrl(8'hB0, 1)));
    chk("b_stable_level", DW'(level), DW'(2));
    edge_in();
    out_ready = 1'b1;
    begin
      int n = 0;
      bit acc = 1'b0;
      while (!acc && n < 20) begin
        @(negedge Clk);
        acc = in_ready;
        n++;
      end
      chk("b3_accept_timeout", DW'(acc), DW'(1));
    end
    edge_in();
    in_valid = 1'b0;
    wait_drain();

    // Flush with level=2; C3 offered in the flush cycle must vanish
    edge_in();
    out_ready = 1'b0;
    drive(8'hC0, 1, 1'b1);
    edge_in();
    drive(8'hC0, 2, 1'b1);
    edge_in();
    drive(8'hC0, 3, 1'b0);
    Flush = 1'b1;
    @(negedge Clk);
    chk("c_level2", DW'(level), DW'(2));
    edge_in();
    Flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge Clk);
    chk("c_out_valid", DW'(out_valid), '0);
    chk("c_out_ctrl", DW'(out_ctrl), '0);
    chk("c_level0", DW'(level), '0);
    chk("c_in_ready", DW'(in_ready), DW'(1));
    chk("c_data_held", out_data, mk_data(8'hC0, 1));
    edge_in();
    out_ready = 1'b1;
    repeat (3) edge_in();

    // Simultaneous in_fire and out_fire at level=1
    out_ready = 1'b0;
    drive(8'hD0, 1, 1'b1);
    edge_in();
    in_valid = 1'b0;
    @(negedge Clk);
    chk("d_level1", DW'(level), DW'(1));
    chk("d_d1", out_data, mk_data(8'hD0, 1));
    edge_in();
    out_ready = 1'b1;
    drive(8'hD0, 2, 1'b1);
    @(negedge Clk);
    chk("d_in_ready", DW'(in_ready), DW'(1));
    edge_in();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge Clk);
    chk("d_replaced", out_data, mk_data(8'hD0, 2));
    chk("d_level_stays1", DW'(level), DW'(1));
    edge_in();
    out_ready = 1'b1;
    wait_drain();

    // Stall counter: 5 stall cycles, survives flush, cleared by reset
    edge_in();
    Reset = 1'b1;
    out_ready = 1'b0;
    edge_in();
    Reset = 1'b0;
    chk("e_cnt_rst", DW'(stall_cnt), '0);
    edge_in();
    drive(8'hE0, 1, 1'b1);
    edge_in();
    in_valid = 1'b0;
    repeat (5) edge_in();
    chk("e_cnt5", DW'(stall_cnt), DW'(exp_stall5));
    Flush = 1'b1;
    out_ready = 1'b1;
    edge_in();
    Flush = 1'b0;
    chk("e_cnt_after_flush", DW'(stall_cnt), DW'(exp_stall5));
    chk("e_level0", DW'(level), '0);
    Reset = 1'b1;
    edge_in();
    Reset = 1'b0;
    chk("e_cnt_cleared", DW'(stall_cnt), '0);
    chk("e_sb_empty", DW'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
